// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Final pipeline stage feeding the register file write port. ALU results are
// written one cycle after acceptance. Loads park the stage in WAIT_LOAD until
// the memory returns data; the word is then aligned, sign/zero-extended and
// written one cycle after mem_rvalid. Idle cycles drive rd_index = 0, which the
// register file treats as "no write".
//
// Optional feature (macro WB_TIMEOUT_EN):
//   Adds a wait counter. A load that sees no mem_rvalid for TIMEOUT_CYCLES
//   cycles is abandoned: the stage returns to IDLE, writes nothing and pulses
//   load_err for one cycle. Without the macro, WAIT_LOAD waits forever and
//   load_err is tied 0.
//
// Handshake (ex_*):
//   ex_ready is high exactly when the FSM is in IDLE. A transfer happens on a
//   cycle where ex_valid & ex_ready. While ex_ready is low the upstream stage
//   holds ex_* stable; nothing is consumed until ex_ready returns high.
//   mem_rvalid is a single-cycle pulse with no back-pressure; it is only
//   meaningful in WAIT_LOAD and is ignored in IDLE.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   ex_valid/ready  execute-stage handshake
//   ex_is_load      instruction is a load
//   ex_rd_index     destination register
//   ex_result       ALU result for non-loads
//   ex_funct3       load type (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; others act as LW)
//   ex_addr_lo      load address bits [1:0]
//   mem_rvalid      load data valid pulse
//   mem_rdata       raw aligned memory word
//   rd_index        register file write index (0 = no write), registered
//   rd_reg_content  register file write data, registered, holds when idle
//   load_err        one-cycle pulse on load timeout
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd_index,
  input  logic [31:0] ex_result,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd_index,
  output logic [31:0] rd_reg_content,
  output logic        load_err
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_addr_q, ld_addr_d;
  logic [4:0]  rd_index_q, rd_index_d;
  logic [31:0] rd_reg_content_q, rd_reg_content_d;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        tmo_expire;

  // ---------------------------------------------------------------------------
  // Load alignment and extension, driven from the captured load attributes.
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (ld_addr_q)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    // Halfword select uses only addr[1]; a misaligned addr[0] is ignored.
    half_sel = ld_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = mem_rdata;
    case (ld_funct3_q)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;  // LW and reserved encodings
    endcase
  end

`ifdef WB_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Load timeout. The counter sits at zero in IDLE, so it is clear on entry to
  // WAIT_LOAD, and counts each waiting cycle without data. Expiry is the cycle
  // in which the count has already covered TIMEOUT_CYCLES-1 empty cycles; a
  // mem_rvalid in that same cycle takes priority and completes normally.
  // ---------------------------------------------------------------------------
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 load_err_q, load_err_d;

  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_expire = 1'b0;
    load_err_d = 1'b0;
    if (state_q == S_IDLE) begin
      tmo_cnt_d = '0;
    end else if (!mem_rvalid) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_expire = 1'b1;
        load_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`else
  assign tmo_expire = 1'b0;
  assign load_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: next state, load capture and write-port drive.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    ld_rd_d          = ld_rd_q;
    ld_funct3_d      = ld_funct3_q;
    ld_addr_d        = ld_addr_q;
    rd_index_d       = 5'd0;              // no write unless a result retires
    rd_reg_content_d = rd_reg_content_q;  // data holds between writes
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            ld_rd_d     = ex_rd_index;
            ld_funct3_d = ex_funct3;
            ld_addr_d   = ex_addr_lo;
            state_d     = S_WAIT_LOAD;
          end else begin
            rd_index_d       = ex_rd_index;
            rd_reg_content_d = ex_result;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (mem_rvalid) begin
          rd_index_d       = ld_rd_q;
          rd_reg_content_d = load_data;
          state_d          = S_IDLE;
        end else if (tmo_expire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      ld_rd_q          <= 5'd0;
      ld_funct3_q      <= 3'd0;
      ld_addr_q        <= 2'd0;
      rd_index_q       <= 5'd0;
      rd_reg_content_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      ld_rd_q          <= ld_rd_d;
      ld_funct3_q      <= ld_funct3_d;
      ld_addr_q        <= ld_addr_d;
      rd_index_q       <= rd_index_d;
      rd_reg_content_q <= rd_reg_content_d;
    end
  end

  assign ex_ready       = (state_q == S_IDLE);
  assign rd_index       = rd_index_q;
  assign rd_reg_content = rd_reg_content_q;

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Directed plus randomised bench for writeback_unit. Expected register-file
// writes are pushed to exp_q as stimulus is driven and popped when the write
// is due. Load formatting is modelled independently with shifts. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd_index;
  logic [31:0] ex_result;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd_index;
  logic [31:0] rd_reg_content;
  logic        load_err;

  logic [36:0] exp_q[$];  // {rd_index, rd_reg_content}
  int          checks = 0;
  int          errors = 0;

  writeback_unit #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_W      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_is_load     (ex_is_load),
    .ex_rd_index    (ex_rd_index),
    .ex_result      (ex_result),
    .ex_funct3      (ex_funct3),
    .ex_addr_lo     (ex_addr_lo),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rd_index       (rd_index),
    .rd_reg_content (rd_reg_content),
    .load_err       (load_err)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] a,
                                      input logic [31:0] d);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = d >> (8 * a);
    hsh = d >> (16 * a[1]);
    case (f3)
      3'd0:    return {{24{bsh[7]}}, bsh[7:0]};
      3'd1:    return {{16{hsh[15]}}, hsh[15:0]};
      3'd4:    return {24'd0, bsh[7:0]};
      3'd5:    return {16'd0, hsh[15:0]};
      default: return d;
    endcase
  endfunction

  // Compare the write that is due this cycle against the scoreboard head.
  task automatic expect_write(input string tag);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rd"}, {27'd0, rd_index}, {27'd0, e[36:32]});
      if (e[36:32] != 5'd0) chk({tag, "_data"}, rd_reg_content, e[31:0]);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_idle();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_rd_index = 5'd0;
    ex_result   = 32'd0;
    ex_funct3   = 3'd0;
    ex_addr_lo  = 2'd0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'd0;
  endtask

  // ALU op: returns with its write visible and already checked.
  task automatic alu_op(input string tag, input logic [4:0] rd, input logic [31:0] res);
    ex_valid    = 1'b1;
    ex_is_load  = 1'b0;
    ex_rd_index = rd;
    ex_result   = res;
    chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
    exp_q.push_back({rd, res});
    cyc();
    ex_valid = 1'b0;
    expect_write(tag);
  endtask

  // Load with `gap` empty wait cycles before mem_rvalid; returns with the
  // load's write visible and checked, and ex_ready re-checked.
  task automatic load_op(input string tag, input logic [2:0] f3, input logic [1:0] a,
                         input logic [4:0] rd, input logic [31:0] data, input int gap);
    ex_valid    = 1'b1;
    ex_is_load  = 1'b1;
    ex_rd_index = rd;
    ex_funct3   = f3;
    ex_addr_lo  = a;
    ex_result   = $urandom();
    chk({tag, "_ready"}, {31'd0, ex_ready}, 32'd1);
    cyc();
    ex_valid = 1'b0;
    chk({tag, "_accept_nowrite"}, {27'd0, rd_index}, 32'd0);
    chk({tag, "_busy"}, {31'd0, ex_ready}, 32'd0);
    for (int i = 0; i < gap; i++) begin
      mem_rdata = $urandom();
      cyc();
      chk({tag, "_wait_busy"}, {31'd0, ex_ready}, 32'd0);
      chk({tag, "_wait_nowrite"}, {27'd0, rd_index}, 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    exp_q.push_back({rd, fmt(f3, a, data)});
    cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    expect_write(tag);
    chk({tag, "_ready_again"}, {31'd0, ex_ready}, 32'd1);
    chk({tag, "_no_err"}, {31'd0, load_err}, 32'd0);
  endtask

  // ---------------------------------------------------------------- sequence
  logic [2:0] f3_tab [8];

  initial begin
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    drive_idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_rd_index", {27'd0, rd_index}, 32'd0);
    chk("rst_content", rd_reg_content, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);

    // ALU write, then one idle cycle with data holding
    alu_op("alu1", 5'd5, 32'hDEADBEEF);
    cyc();
    chk("alu1_idle_rd", {27'd0, rd_index}, 32'd0);
    chk("alu1_idle_hold", rd_reg_content, 32'hDEADBEEF);

    // LB from the top byte with a 3-cycle busy window, then idle after
    load_op("lb3", 3'd0, 2'd3, 5'd9, 32'h80AB_CDEF, 2);
    cyc();
    chk("lb3_once", {27'd0, rd_index}, 32'd0);
    chk("lb3_hold", rd_reg_content, 32'hFFFF_FF80);

    // Halfword / word formatting on the same raw word
    load_op("lhu2", 3'd5, 2'd2, 5'd10, 32'h8001_1234, 0);
    load_op("lh2",  3'd1, 2'd2, 5'd11, 32'h8001_1234, 1);
    load_op("lw2",  3'd2, 2'd2, 5'd12, 32'h8001_1234, 0);
    load_op("lh3",  3'd1, 2'd3, 5'd13, 32'h8001_1234, 0);  // addr[0] ignored
    load_op("lbu1", 3'd4, 2'd1, 5'd14, 32'h0000_F200, 0);
    load_op("lr7",  3'd7, 2'd1, 5'd15, 32'hCAFE_F00D, 0);  // reserved acts as LW

    // mem_rvalid in IDLE is ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    cyc();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_nowrite", {27'd0, rd_index}, 32'd0);
    chk("idle_rvalid_ready", {31'd0, ex_ready}, 32'd1);

    // Reset while waiting: pending load dropped
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_index = 5'd20; ex_funct3 = 3'd2;
    cyc();
    ex_valid = 1'b0;
    cyc();
    chk("rstmid_busy", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hAAAA_5555;
    chk("rstmid_ready", {31'd0, ex_ready}, 32'd1);
    cyc();
    mem_rvalid = 1'b0;
    chk("rstmid_nowrite", {27'd0, rd_index}, 32'd0);
    chk("rstmid_ready2", {31'd0, ex_ready}, 32'd1);

    // Load to rd=0, then back-to-back ALU rd=7 in the completion cycle
    load_op("ld_rd0", 3'd2, 2'd0, 5'd0, 32'h0BAD_F00D, 1);
    alu_op("alu7", 5'd7, 32'h0000_0777);
    alu_op("alu_rd0", 5'd0, 32'h1111_2222);
    chk("alu_rd0_hold", rd_reg_content, 32'h1111_2222);

    // Randomised mix of ALU ops and loads
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        alu_op("rnd_alu", 5'($urandom_range(0, 31)), $urandom());
      end else begin
        load_op("rnd_ld", f3_tab[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), $urandom(), $urandom_range(0, 3));
      end
    end

`ifdef WB_TIMEOUT_EN
    // Timeout after 4 empty wait cycles
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_index = 5'd21; ex_funct3 = 3'd2;
    cyc();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("tmo_wait_err", {31'd0, load_err}, 32'd0);
      chk("tmo_wait_busy", {31'd0, ex_ready}, 32'd0);
    end
    cyc();
    chk("tmo_err", {31'd0, load_err}, 32'd1);
    chk("tmo_nowrite", {27'd0, rd_index}, 32'd0);
    chk("tmo_ready", {31'd0, ex_ready}, 32'd1);
    cyc();
    chk("tmo_err_pulse", {31'd0, load_err}, 32'd0);

    // Data arriving in the expiry cycle wins
    load_op("tmo_race", 3'd2, 2'd0, 5'd22, 32'h5A5A_A5A5, 3);
`else
    // Without the timeout, a long wait still completes normally
    load_op("long_wait", 3'd2, 2'd0, 5'd22, 32'h5A5A_A5A5, 40);
`endif

    cyc();
    chk("final_idle", {27'd0, rd_index}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
